// File: rtl/calc_pkg.sv
// Shared opcode and state encodings for calc_seq_core and its multiply/divide engine.
// Holds no logic.
package calc_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_CLR  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_BUSY_MUL = 2'd1;
  localparam logic [1:0] ST_BUSY_DIV = 2'd2;

  // Iteration counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_muldiv_engine.sv
// Iterative shift-add multiplier / restoring divider sharing one shift register; one bit per cycle.
// Latency: WIDTH cycles after start. There is no backpressure: start is ignored while busy, and last marks the final step.
module seq_muldiv_engine
  import calc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] result,
  output logic             hi_nz
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // MUL: hi:lo is the partial product, with the multiplier shifting out of lo.
  // DIV: hi is the remainder and lo shifts the dividend out and the quotient in.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - opd_q;
    div_ge    = (div_shift >= {1'b0, opd_q});
    if (mode_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign busy   = busy_q;
  assign last   = busy_q && (cnt_q == CW'(1));
  assign result = step_lo;
  assign hi_nz  = !mode_q && (|step_hi);

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opd_d  = opd_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    busy_d = busy_q;
    if (start && !busy_q) begin
      hi_d   = '0;
      lo_d   = op_b;
      opd_d  = op_a;
      cnt_d  = CW'(WIDTH);
      mode_d = div_mode;
      busy_d = 1'b1;
    end else if (busy_q) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q - CW'(1);
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opd_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opd_q  <= opd_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/calc_seq_core.sv
// Accumulator calculator: the FSM, single-cycle ALU and flags, with iterative MUL/DIV. Saturation is optional via CALC_SATURATE_EN.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL and non-zero DIV; in_ready is low while MUL/DIV iterate.
module calc_seq_core
  import calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             use_prev,
  input  logic [IMM_W-1:0] imm_a,
  input  logic [IMM_W-1:0] imm_b,
  output logic [WIDTH-1:0] accum,
  output logic             done,
  output logic             ovf,
  output logic             div_zero,
  output logic             illegal
);

`ifdef CALC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] accum_q, accum_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             div_zero_q, div_zero_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] add_res, sub_res, mul_res;

  logic             eng_start, eng_div, eng_busy, eng_last, eng_hi_nz;
  logic [WIDTH-1:0] eng_result;

  assign in_ready = (state_q == ST_IDLE) && !eng_busy;
  assign accept   = in_valid && in_ready;
  assign opa      = WIDTH'(imm_a);
  assign opb      = use_prev ? accum_q : WIDTH'(imm_b);

  assign add_full = {1'b0, opa} + {1'b0, opb};
  assign sub_full = {1'b0, opa} - {1'b0, opb};
  assign add_res  = (SAT_EN && add_full[WIDTH]) ? '1 : add_full[WIDTH-1:0];
  assign sub_res  = (SAT_EN && sub_full[WIDTH]) ? '0 : sub_full[WIDTH-1:0];
  assign mul_res  = (SAT_EN && eng_hi_nz) ? '1 : eng_result;

  seq_muldiv_engine #(.WIDTH(WIDTH)) u_engine (
    .clk      (clk),
    .reset    (reset),
    .start    (eng_start),
    .div_mode (eng_div),
    .op_a     (opa),
    .op_b     (opb),
    .busy     (eng_busy),
    .last     (eng_last),
    .result   (eng_result),
    .hi_nz    (eng_hi_nz)
  );

  // Every commit rewrites all three flags, so stale flags never outlive the next op.
  always_comb begin
    state_d    = state_q;
    accum_d    = accum_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    div_zero_d = div_zero_q;
    illegal_d  = illegal_q;
    eng_start  = 1'b0;
    eng_div    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          done_d     = 1'b1;
          ovf_d      = 1'b0;
          div_zero_d = 1'b0;
          illegal_d  = 1'b0;
          case (op)
            OP_ADD: begin
              accum_d = add_res;
              ovf_d   = add_full[WIDTH];
            end
            OP_SUB: begin
              accum_d = sub_res;
              ovf_d   = sub_full[WIDTH];
            end
            OP_MUL: begin
              done_d     = 1'b0;
              ovf_d      = ovf_q;
              div_zero_d = div_zero_q;
              illegal_d  = illegal_q;
              eng_start  = 1'b1;
              state_d    = ST_BUSY_MUL;
            end
            OP_DIV: begin
              if (opa == '0) begin
                div_zero_d = 1'b1;
              end else begin
                done_d     = 1'b0;
                ovf_d      = ovf_q;
                div_zero_d = div_zero_q;
                illegal_d  = illegal_q;
                eng_start  = 1'b1;
                eng_div    = 1'b1;
                state_d    = ST_BUSY_DIV;
              end
            end
            OP_CLR:  accum_d = '0;
            OP_LOAD: accum_d = opa;
            default: illegal_d = 1'b1;
          endcase
        end
      end
      ST_BUSY_MUL: begin
        if (eng_last) begin
          accum_d    = mul_res;
          ovf_d      = eng_hi_nz;
          div_zero_d = 1'b0;
          illegal_d  = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_BUSY_DIV: begin
        if (eng_last) begin
          accum_d    = eng_result;
          ovf_d      = 1'b0;
          div_zero_d = 1'b0;
          illegal_d  = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      accum_q    <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      div_zero_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      accum_q    <= accum_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      div_zero_q <= div_zero_d;
      illegal_q  <= illegal_d;
    end
  end

  assign accum    = accum_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign div_zero = div_zero_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_calc_seq_core.sv
// Directed bench for calc_seq_core: a 32-bit instance runs the main sequence, and a 16-bit instance covers multiply overflow.
module tb_calc_seq_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, use_prev, done, ovf, div_zero, illegal;
  logic [2:0]  op;
  logic [13:0] imm_a, imm_b;
  logic [31:0] accum;

  logic        in_valid16, in_ready16, use_prev16, done16, ovf16, div_zero16, illegal16;
  logic [2:0]  op16;
  logic [13:0] imm_a16, imm_b16;
  logic [15:0] accum16;

  int n_cmp = 0;
  int n_err = 0;
  int lat, busy_lo, dcount;

  always #5 clk = ~clk;

  calc_seq_core #(.WIDTH(32), .IMM_W(14)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .use_prev(use_prev), .imm_a(imm_a), .imm_b(imm_b), .accum(accum), .done(done),
    .ovf(ovf), .div_zero(div_zero), .illegal(illegal)
  );

  calc_seq_core #(.WIDTH(16), .IMM_W(14)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .use_prev(use_prev16), .imm_a(imm_a16), .imm_b(imm_b16), .accum(accum16), .done(done16),
    .ovf(ovf16), .div_zero(div_zero16), .illegal(illegal16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one instruction for exactly one rising edge.
  task automatic issue(input logic [2:0] o, input logic up, input logic [13:0] a, input logic [13:0] b);
    in_valid = 1'b1;
    op       = o;
    use_prev = up;
    imm_a    = a;
    imm_b    = b;
    chk("ready_at_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts negedges until done; optionally pulses in_valid mid-operation.
  task automatic wait_done(output int l, output int bl, input int pulse_at);
    l  = -1;
    bl = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (n == pulse_at) begin
        in_valid = 1'b1;
        op       = 3'b101;
        use_prev = 1'b0;
        imm_a    = 14'd1;
      end
      if (!in_ready) bl++;
      if (done) begin
        l = n;
        break;
      end
    end
  endtask

  task automatic run16(input logic [2:0] o, input logic up, input logic [13:0] a, output int l);
    in_valid16 = 1'b1;
    op16       = o;
    use_prev16 = up;
    imm_a16    = a;
    imm_b16    = 14'd0;
    @(posedge clk);
    #1 in_valid16 = 1'b0;
    l = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done16) begin
        l = n;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; op = 3'd0; use_prev = 1'b0; imm_a = '0; imm_b = '0;
    in_valid16 = 1'b0; op16 = 3'd0; use_prev16 = 1'b0; imm_a16 = '0; imm_b16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_accum", accum, 32'd0);
    chk("rst_flags", {28'd0, done, ovf, div_zero, illegal}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    issue(3'b000, 1'b0, 14'd5, 14'd7);
    wait_done(lat, busy_lo, 0);
    chk("add_lat", lat, 32'd1);
    chk("add_accum", accum, 32'd12);
    chk("add_ovf", {31'd0, ovf}, 32'd0);

    issue(3'b001, 1'b1, 14'd3, 14'd0);
    wait_done(lat, busy_lo, 0);
    chk("sub_lat", lat, 32'd1);
    chk("sub_ovf", {31'd0, ovf}, 32'd1);
`ifdef CALC_SATURATE_EN
    chk("sub_accum", accum, 32'd0);
`else
    chk("sub_accum", accum, 32'hFFFF_FFF7);
`endif
    @(negedge clk);
    chk("done_width", {31'd0, done}, 32'd0);

    issue(3'b010, 1'b0, 14'd100, 14'd200);
    wait_done(lat, busy_lo, 10);
    chk("mul_lat", lat, 32'd33);
    chk("mul_busy_cycles", busy_lo, 32'd32);
    chk("mul_accum", accum, 32'd20000);
    chk("mul_ovf", {31'd0, ovf}, 32'd0);

    issue(3'b101, 1'b0, 14'd16383, 14'd0);
    wait_done(lat, busy_lo, 0);
    chk("load_accum", accum, 32'd16383);
    issue(3'b010, 1'b1, 14'd16383, 14'd0);
    wait_done(lat, busy_lo, 0);
    chk("mulsq_accum", accum, 32'd268402689);
    chk("mulsq_ovf", {31'd0, ovf}, 32'd0);

    issue(3'b101, 1'b0, 14'd16000, 14'd0);
    wait_done(lat, busy_lo, 0);
    issue(3'b011, 1'b1, 14'd7, 14'd0);
    wait_done(lat, busy_lo, 0);
    chk("div_lat", lat, 32'd33);
    chk("div_accum", accum, 32'd2285);
    chk("div_flags", {29'd0, ovf, div_zero, illegal}, 32'd0);

    issue(3'b011, 1'b0, 14'd0, 14'd9);
    wait_done(lat, busy_lo, 0);
    chk("div0_lat", lat, 32'd1);
    chk("div0_flag", {31'd0, div_zero}, 32'd1);
    chk("div0_accum", accum, 32'd2285);

    issue(3'b100, 1'b0, 14'd3, 14'd3);
    wait_done(lat, busy_lo, 0);
    chk("clr_accum", accum, 32'd0);
    chk("clr_divzero", {31'd0, div_zero}, 32'd0);

    issue(3'b101, 1'b0, 14'd55, 14'd0);
    wait_done(lat, busy_lo, 0);
    issue(3'b010, 1'b0, 14'd100, 14'd200);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_accum", accum, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", dcount, 32'd0);

    issue(3'b111, 1'b0, 14'd4, 14'd4);
    wait_done(lat, busy_lo, 0);
    chk("ill_lat", lat, 32'd1);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_accum", accum, 32'd0);

    issue(3'b000, 1'b0, 14'd1, 14'd2);
    wait_done(lat, busy_lo, 0);
    chk("ill_cleared", {31'd0, illegal}, 32'd0);
    chk("add2_accum", accum, 32'd3);

    run16(3'b101, 1'b0, 14'd16383, lat);
    chk("w16_load", {16'd0, accum16}, 32'd16383);
    run16(3'b010, 1'b1, 14'd16383, lat);
    chk("w16_mul_lat", lat, 32'd17);
    chk("w16_mul_ovf", {31'd0, ovf16}, 32'd1);
`ifdef CALC_SATURATE_EN
    chk("w16_mul_accum", {16'd0, accum16}, 32'h0000_FFFF);
`else
    chk("w16_mul_accum", {16'd0, accum16}, 32'h0000_8001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
